// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage datapath and the ALU.
interface alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUcont;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;

  // Datapath side: supplies operands and control, consumes results.
  modport master (
    output A, B, ALUcont,
    input  result, zero, overflow, result_q, zero_q, overflow_q
  );

  // ALU side: consumes operands and control, produces results.
  modport slave (
    input  A, B, ALUcont,
    output result, zero, overflow, result_q, zero_q, overflow_q
  );
endinterface

// File: rtl/alu.sv
// MIPS-style integer ALU: combinational result/zero/overflow plus a
// one-cycle registered copy for pipelined consumers.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);
  localparam int unsigned MSB = WIDTH - 1;

  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf_arith;
  logic             less;
  logic [WIDTH-1:0] result_c;
  logic             zero_c;
  logic             overflow_c;

  // Shared adder for ADD/SUB/SLT; ALUcont[2] selects subtraction (invert B, carry in 1).
  always_comb begin
    cin       = bus.ALUcont[2];
    b_eff     = cin ? ~bus.B : bus.B;
    sum       = bus.A + b_eff + {{(WIDTH-1){1'b0}}, cin};
    // Signed overflow: operands (as fed to the adder) agree in sign, sum disagrees.
    ovf_arith = (bus.A[MSB] == b_eff[MSB]) && (sum[MSB] != bus.A[MSB]);
    // Correcting the sign bit by overflow keeps SLT right at operand extremes.
    less      = sum[MSB] ^ ovf_arith;
  end

  // Operation select, zero detect and overflow qualification.
  always_comb begin
    result_c = '0;
    case (bus.ALUcont)
      3'b000: result_c = bus.A & bus.B;
      3'b001: result_c = bus.A | bus.B;
      3'b010: result_c = sum;
      3'b011: result_c = ~(bus.A | bus.B);
      3'b100: result_c = bus.A & ~bus.B;
      3'b101: result_c = bus.A | ~bus.B;
      3'b110: result_c = sum;
      3'b111: result_c = {{(WIDTH-1){1'b0}}, less};
      default: result_c = '0;
    endcase
    zero_c     = (result_c == '0);
    overflow_c = ((bus.ALUcont == 3'b010) || (bus.ALUcont == 3'b110)) ? ovf_arith : 1'b0;
  end

  assign bus.result   = result_c;
  assign bus.zero     = zero_c;
  assign bus.overflow = overflow_c;

  // Pipeline register: reset presents a cleared result with zero asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result_q   <= '0;
      bus.zero_q     <= 1'b1;
      bus.overflow_q <= 1'b0;
    end else begin
      bus.result_q   <= result_c;
      bus.zero_q     <= zero_c;
      bus.overflow_q <= overflow_c;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: combinational ops, boundaries, registered stage.
module tb_alu;
  logic clk;
  logic reset;
  int   tests;
  int   failed;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010,
                         OP_NOR = 3'b011, OP_ANDN = 3'b100, OP_ORN = 3'b101,
                         OP_SUB = 3'b110, OP_SLT = 3'b111;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.A       = a;
    bus.B       = b;
    bus.ALUcont = op;
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.A = '0; bus.B = '0; bus.ALUcont = OP_ADD;
    #2;

    apply(32'd0, 32'd0, OP_ADD);
    check32("add0_res", bus.result, 32'd0);
    check1 ("add0_zero", bus.zero, 1'b1);
    check1 ("add0_ovf", bus.overflow, 1'b0);

    apply(32'd150, 32'd50, OP_AND);
    check32("and_res", bus.result, 32'd18);
    check1 ("and_zero", bus.zero, 1'b0);
    apply(32'd1, 32'd2, OP_OR);
    check32("or_res", bus.result, 32'd3);
    check1 ("or_zero", bus.zero, 1'b0);

    apply(32'd100, 32'd50, OP_SUB);
    check32("sub100_res", bus.result, 32'd50);
    apply(32'd10, 32'd5, OP_SUB);
    check32("sub10_res", bus.result, 32'd5);
    apply(32'd5, 32'd5, OP_SUB);
    check32("sub5_res", bus.result, 32'd0);
    check1 ("sub5_zero", bus.zero, 1'b1);
    apply(32'd0, 32'd0, OP_SUB);
    check32("sub0_res", bus.result, 32'd0);
    check1 ("sub0_zero", bus.zero, 1'b1);

    apply(32'h7FFF_FFFF, 32'd1, OP_ADD);
    check32("addovf_res", bus.result, 32'h8000_0000);
    check1 ("addovf_ovf", bus.overflow, 1'b1);
    apply(32'h8000_0000, 32'd1, OP_SUB);
    check32("subovf_res", bus.result, 32'h7FFF_FFFF);
    check1 ("subovf_ovf", bus.overflow, 1'b1);
    apply(32'h8000_0000, 32'd1, OP_AND);
    check32("andovf_res", bus.result, 32'd0);
    check1 ("andovf_ovf", bus.overflow, 1'b0);
    apply(32'd5, 32'd3, OP_ADD);
    check32("add_res", bus.result, 32'd8);
    check1 ("add_ovf", bus.overflow, 1'b0);
    apply(32'd3, 32'd5, OP_SUB);
    check32("subneg_res", bus.result, 32'hFFFF_FFFE);
    check1 ("subneg_ovf", bus.overflow, 1'b0);

    apply(32'hFFFF_FFFF, 32'd1, OP_SLT);
    check32("slt_m1_1", bus.result, 32'd1);
    check1 ("slt_m1_1_zero", bus.zero, 1'b0);
    apply(32'd1, 32'hFFFF_FFFF, OP_SLT);
    check32("slt_1_m1", bus.result, 32'd0);
    check1 ("slt_1_m1_zero", bus.zero, 1'b1);
    apply(32'h8000_0000, 32'h7FFF_FFFF, OP_SLT);
    check32("slt_ext", bus.result, 32'd1);
    check1 ("slt_ext_ovf", bus.overflow, 1'b0);
    apply(32'h7FFF_FFFF, 32'h8000_0000, OP_SLT);
    check32("slt_ext_rev", bus.result, 32'd0);

    apply(32'd0, 32'd0, OP_NOR);
    check32("nor_res", bus.result, 32'hFFFF_FFFF);
    apply(32'h0000_00F0, 32'h0000_0030, OP_ANDN);
    check32("andn_res", bus.result, 32'h0000_00C0);
    apply(32'd0, 32'hFFFF_FFFE, OP_ORN);
    check32("orn_res", bus.result, 32'd1);

    // Registered stage: reset with live nonzero operation.
    @(negedge clk);
    reset = 1'b1;
    apply(32'd100, 32'd50, OP_SUB);
    @(posedge clk); #1;
    check32("rst_result_q", bus.result_q, 32'd0);
    check1 ("rst_zero_q", bus.zero_q, 1'b1);
    check1 ("rst_ovf_q", bus.overflow_q, 1'b0);
    check32("rst_live_res", bus.result, 32'd50);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check32("q_sub_res", bus.result_q, 32'd50);
    check1 ("q_sub_zero", bus.zero_q, 1'b0);

    @(negedge clk);
    apply(32'h7FFF_FFFF, 32'd1, OP_ADD);
    check32("q_hold", bus.result_q, 32'd50);
    @(posedge clk); #1;
    check32("q_add_res", bus.result_q, 32'h8000_0000);
    check1 ("q_add_ovf", bus.overflow_q, 1'b1);

    @(negedge clk);
    apply(32'd7, 32'd7, OP_SUB);
    @(posedge clk); #1;
    check32("q_zero_res", bus.result_q, 32'd0);
    check1 ("q_zero_zero", bus.zero_q, 1'b1);

    @(negedge clk);
    apply(32'h7FFF_FFFF, 32'd1, OP_ADD);
    reset = 1'b1;
    @(posedge clk); #1;
    check32("mid_rst_result_q", bus.result_q, 32'd0);
    check1 ("mid_rst_ovf_q", bus.overflow_q, 1'b0);
    check1 ("mid_rst_zero_q", bus.zero_q, 1'b1);
    check32("mid_rst_live", bus.result, 32'h8000_0000);
    check1 ("mid_rst_live_ovf", bus.overflow, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit MIPS-style integer ALU used in the datapath execute stage.
- Computes a result and a zero flag combinationally from operands A and B under a 3-bit control code ALUcont.
- Also provides a signed-overflow flag and a one-cycle registered copy of the outputs for pipelined consumers.
- Clocked on clk with synchronous active-high reset.

Parameters:
- WIDTH, 32, operand/result width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- ALUcont  input  3  operation select; encodings listed below.
- result  output  WIDTH  combinational operation result.
- zero  output  1  combinational; 1 iff result == 0.
- overflow  output  1  combinational signed overflow; meaningful for ADD/SUB only.
- result_q  output  WIDTH  result registered one cycle.
- zero_q  output  1  zero registered one cycle.
- overflow_q  output  1  overflow registered one cycle.

Behaviour:
- ALUcont encodings:
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B.
  - 011 NOR: ~(A | B).
  - 100 ANDN: A & ~B.
  - 101 ORN: A | ~B.
  - 110 SUB: A - B.
  - 111 SLT: 1 if $signed(A) < $signed(B), else 0, zero-extended to WIDTH.
- Implementation structure:
  - ADD/SUB/SLT share one adder computing A + (B or ~B) + cin, with cin = ALUcont[2].
  - SLT derives "less" as sum MSB XOR signed overflow of A - B, so it stays correct at operand extremes.
- result, zero and overflow are purely combinational; they settle within the same cycle as any input change and do not depend on clk or reset.
- overflow:
  - ADD: 1 iff A and B have the same sign and the sum's sign differs.
  - SUB: 1 iff A and B have different signs and the difference's sign differs from A.
  - All other codes: 0.
  - Overflow never alters result; wrap-around is silent (MIPS addu/subu semantics).
- zero reflects result for every operation, including SLT (zero = 1 when SLT is false).
- Registered stage:
  - On a rising clk edge with reset = 1: result_q <= 0, zero_q <= 1, overflow_q <= 0.
  - Otherwise result_q/zero_q/overflow_q capture result/zero/overflow.
  - Latency is exactly 1 cycle; no enable and no handshake, so a new operation can be accepted every cycle.
- Reset asserted mid-operation affects only the registered outputs on that edge; combinational outputs keep tracking the inputs.
- Outputs never go X for known inputs; every ALUcont value is defined.
- Boundary requirements:
  - 0x7FFFFFFF + 1 = 0x80000000 with overflow = 1.
  - 0x80000000 - 1 = 0x7FFFFFFF with overflow = 1.
  - SLT 0x80000000 vs 0x7FFFFFFF gives 1.
  - 0 - 0 gives result 0, zero = 1.

Test Plan:
- A=0, B=0, ADD -> result=0, zero=1, overflow=0.
- A=150, B=50, AND -> 18, zero=0; then A=1, B=2, OR -> 3, zero=0.
- A=100, B=50, SUB -> 50; A=10, B=5, SUB -> 5; A=5, B=5, SUB -> 0 with zero=1.
- A=0x7FFFFFFF, B=1, ADD -> 0x80000000 with overflow=1; A=0x80000000, B=1, SUB -> 0x7FFFFFFF with overflow=1; AND with the same operands -> overflow=0.
- SLT with A=-1, B=1 -> 1; A=1, B=-1 -> 0 (zero=1); A=0x80000000, B=0x7FFFFFFF -> 1. NOR 0,0 -> 0xFFFFFFFF; ANDN 0xF0,0x30 -> 0xC0; ORN 0,0xFFFFFFFE -> 1.
- Registered stage: hold reset high for 1 clk -> result_q=0, zero_q=1, overflow_q=0. Release reset with A=100, B=50, SUB -> result_q=50 one edge later. Assert reset mid-stream -> registered outputs clear on that edge while result still shows the live value.
